// File: rtl/dmem_responder_if.sv
// M-stage memory bus between the datapath (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic        MemWriteM;
  logic        MemtoRegM;
  logic [31:0] ReadDataM;
  logic        MemStallM;
  logic        MisalignM;

  modport master (
    output ALUOutM, WriteDataM, MemWriteM, MemtoRegM,
    input  ReadDataM, MemStallM, MisalignM
  );

  modport slave (
    input  ALUOutM, WriteDataM, MemWriteM, MemtoRegM,
    output ReadDataM, MemStallM, MisalignM
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with programmable wait states and a pipeline stall request.
// Optional misaligned-access trapping is enabled by defining DMEM_MISALIGN_EXC_EN.
module dmem_responder #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t                 state, stateNext;
  logic [3:0]             count, countNext;
  logic                   req, stall, enterDone, misaligned, doWrite;
  logic [ADDR_BITS-1:0]   wordIdx;
  logic [31:0]            mem [2**ADDR_BITS];
  logic [31:0]            readData;
  logic                   misalignReg;
  logic                   unusedAddr;

  assign req     = bus.MemWriteM | bus.MemtoRegM;
  assign wordIdx = bus.ALUOutM[ADDR_BITS+1:2];
  assign unusedAddr = ^{bus.ALUOutM[31:ADDR_BITS+2], bus.ALUOutM[1:0]};

`ifdef DMEM_MISALIGN_EXC_EN
  assign misaligned = |bus.ALUOutM[1:0];
`else
  assign misaligned = 1'b0;
`endif

  assign enterDone = (stateNext == DONE);
  // The array has no reset, so gate the write with reset to keep a held request from landing during reset.
  assign doWrite   = enterDone & reset & bus.MemWriteM & ~misaligned;

  always_comb begin
    stateNext = state;
    countNext = count;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          stall = 1'b1;
          if (WAIT_CYCLES == 0) begin
            stateNext = DONE;
          end else begin
            stateNext = BUSY;
            countNext = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (count == '0) stateNext = DONE;
        else             countNext = count - 4'd1;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      readData    <= '0;
      misalignReg <= 1'b0;
    end else begin
      state       <= stateNext;
      count       <= countNext;
      if (enterDone) readData <= misaligned ? '0 : mem[wordIdx];
      misalignReg <= enterDone & misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (doWrite) mem[wordIdx] <= bus.WriteDataM;
  end

  assign bus.ReadDataM = readData;
  assign bus.MemStallM = stall;
`ifdef DMEM_MISALIGN_EXC_EN
  assign bus.MisalignM = misalignReg;
`else
  assign bus.MisalignM = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, corner sequences and a randomized model run.
module tb_dmem_responder;

`ifdef DMEM_MISALIGN_EXC_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   passCnt  = 0;
  int   totalCnt = 0;

  dmem_responder_if bus ();
  dmem_responder_if busZ ();

  dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dmem_responder #(.ADDR_BITS(4), .WAIT_CYCLES(0)) dutZ (
    .clk   (clk),
    .reset (reset),
    .bus   (busZ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic        re;
    logic        chkRd;
    logic [31:0] expRd;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] refMem   [1024];
  bit          refValid [1024];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input bit z, input logic [31:0] addr, input logic [31:0] data,
                       input logic we, input logic re);
    if (z) begin
      busZ.ALUOutM = addr; busZ.WriteDataM = data; busZ.MemWriteM = we; busZ.MemtoRegM = re;
    end else begin
      bus.ALUOutM = addr; bus.WriteDataM = data; bus.MemWriteM = we; bus.MemtoRegM = re;
    end
  endtask

  function automatic logic stallOf(input bit z);
    return z ? busZ.MemStallM : bus.MemStallM;
  endfunction

  function automatic logic [31:0] rdOf(input bit z);
    return z ? busZ.ReadDataM : bus.ReadDataM;
  endfunction

  function automatic logic misOf(input bit z);
    return z ? busZ.MisalignM : bus.MisalignM;
  endfunction

  // Called shortly after a falling edge with the DUT idle; returns shortly after a falling edge, idle.
  task automatic access(input bit z, input logic [31:0] addr, input logic [31:0] data,
                        input logic we, input logic re, input int expStall,
                        input logic chkRd, input logic [31:0] expRd, input logic expMis,
                        input string tag);
    int n;
    drive(z, addr, data, we, re);
    #1;
    n = 0;
    while (stallOf(z) && n < 40) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({tag, " stall"}, 32'(n), 32'(expStall));
    if (chkRd) chk({tag, " rdata"}, rdOf(z), expRd);
    chk({tag, " misalign"}, 32'(misOf(z)), 32'(expMis));
    drive(z, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk({tag, " misalign drop"}, 32'(misOf(z)), 32'd0);
    if (chkRd) chk({tag, " rdata hold"}, rdOf(z), expRd);
  endtask

  initial begin
    logic [31:0] addr, data, expRd;
    logic [1:0]  low;
    int          idx, kind;
    logic        we, re, mis, chkRd;

    vecs[0] = '{32'h0000_0040, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{32'h0000_0040, 32'h0,         1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{32'h0000_0010, 32'hAAAA_0000, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{32'h0000_0010, 32'h5555_FFFF, 1'b1, 1'b1, 1'b1, 32'hAAAA_0000};
    vecs[4] = '{32'h0000_0010, 32'h0,         1'b0, 1'b1, 1'b1, 32'h5555_FFFF};
    vecs[5] = '{32'h0000_0020, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{32'h4000_0040, 32'h0102_0304, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[7] = '{32'h0000_0020, 32'h0,         1'b0, 1'b1, 1'b1, 32'hCAFE_F00D};
    vecs[8] = '{32'h0000_0040, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0102_0304};
    for (int i = 0; i < 1024; i++) begin
      refMem[i]   = '0;
      refValid[i] = 1'b0;
    end

    // Reset values, and stall following req while held in reset
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b1, '0, '0, 1'b0, 1'b0);
    #1;
    chk("reset rdata", bus.ReadDataM, 32'h0);
    chk("reset misalign", 32'(bus.MisalignM), 32'd0);
    chk("reset stall idle", 32'(bus.MemStallM), 32'd0);
    bus.MemtoRegM = 1'b1;
    #1;
    chk("reset stall follows req", 32'(bus.MemStallM), 32'd1);
    bus.MemtoRegM = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      access(1'b0, vecs[i].addr, vecs[i].data, vecs[i].we, vecs[i].re, 3,
             vecs[i].chkRd, vecs[i].expRd, 1'b0, $sformatf("vec%0d", i));
    end

    // Reset during BUSY of a store: no write, read data cleared
    drive(1'b0, 32'h0000_0020, 32'h1111_1111, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk("rstMid busy stall", 32'(bus.MemStallM), 32'd1);
    reset = 1'b0;
    #1;
    chk("rstMid rdata cleared", bus.ReadDataM, 32'h0);
    chk("rstMid stall follows req", 32'(bus.MemStallM), 32'd1);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("rstMid stall idle", 32'(bus.MemStallM), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    access(1'b0, 32'h0000_0020, 32'h0, 1'b0, 1'b1, 3, 1'b1, 32'hCAFE_F00D, 1'b0, "rstMid reload");

    // Misaligned store to 0x22
    access(1'b0, 32'h0000_0022, 32'h0BAD_F00D, 1'b1, 1'b0, 3, 1'b1,
           MIS_EN ? 32'h0 : 32'hCAFE_F00D, MIS_EN, "misSt");
    access(1'b0, 32'h0000_0020, 32'h0, 1'b0, 1'b1, 3, 1'b1,
           MIS_EN ? 32'hCAFE_F00D : 32'h0BAD_F00D, 1'b0, "misLd");

    // Randomized accesses against a word-array model
    for (int i = 0; i < 40; i++) begin
      idx  = $urandom_range(64, 71);
      kind = $urandom_range(0, 2);
      low  = 2'b00;
      if ($urandom_range(0, 3) == 0) low = 2'($urandom_range(1, 3));
      addr = ($urandom & 32'hFFFF_F000) | (32'(idx) << 2) | 32'(low);
      data = $urandom;
      if (!refValid[idx] && kind == 1) kind = 0;
      we  = (kind != 1);
      re  = (kind != 0);
      mis = MIS_EN && (low != 2'b00);
      if (mis) begin
        chkRd = 1'b1;
        expRd = 32'h0;
      end else begin
        chkRd = refValid[idx];
        expRd = refMem[idx];
        if (we) begin
          refMem[idx]   = data;
          refValid[idx] = 1'b1;
        end
      end
      access(1'b0, addr, data, we, re, 3, chkRd, expRd, mis, $sformatf("rand%0d", i));
    end

    // Zero wait states and 4-bit word index on the second instance
    access(1'b1, 32'h0000_0000, 32'h1234_5678, 1'b1, 1'b0, 1, 1'b0, 32'h0, 1'b0, "zSt");
    access(1'b1, 32'h0000_0040, 32'h0, 1'b0, 1'b1, 1, 1'b1, 32'h1234_5678, 1'b0, "zWrapLd");
    access(1'b1, 32'h0000_0004, 32'h0000_BEEF, 1'b1, 1'b0, 1, 1'b0, 32'h0, 1'b0, "zSt2");

    // Back-to-back loads with req held high: DONE cycles two apart
    drive(1'b1, 32'h0000_0000, '0, 1'b0, 1'b1);
    #1;
    chk("b2b c0 stall", 32'(busZ.MemStallM), 32'd1);
    @(negedge clk);
    #1;
    chk("b2b c1 stall", 32'(busZ.MemStallM), 32'd0);
    chk("b2b c1 rdata", busZ.ReadDataM, 32'h1234_5678);
    drive(1'b1, 32'h0000_0004, '0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk("b2b c2 stall", 32'(busZ.MemStallM), 32'd1);
    @(negedge clk);
    #1;
    chk("b2b c3 stall", 32'(busZ.MemStallM), 32'd0);
    chk("b2b c3 rdata", busZ.ReadDataM, 32'h0000_BEEF);
    drive(1'b1, '0, '0, 1'b0, 1'b0);
    @(negedge clk);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the pipeline's memory stage. Accepts the word-access request the datapath drives during M (address, store data, write and load enables) and returns load data. Inserts a programmable number of wait states and holds the pipeline with a stall request until each access completes. Sits between the datapath's M-stage outputs and its M-stage data input.

## Interface
Parameters:
- `ADDR_BITS`, default 10: word-index width; memory holds 2^ADDR_BITS 32-bit words.
- `WAIT_CYCLES`, default 2: wait states per access, 0..15.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ALUOutM`  in  32  byte address of the access.
- `WriteDataM`  in  32  store data.
- `MemWriteM`  in  1  store request.
- `MemtoRegM`  in  1  load request.
- `ReadDataM`  out  32  load data, registered.
- `MemStallM`  out  1  stall request to the hazard unit; the pipeline freezes F/D/E/M while high.
- `MisalignM`  out  1  misaligned-access flag (see Configuration).

## Operation
- `req = MemWriteM | MemtoRegM`.
- Word index is `ALUOutM[ADDR_BITS+1:2]`. Upper address bits are ignored, so addresses wrap modulo the memory size.
- FSM states: IDLE, BUSY, DONE.
  - IDLE + req: if `WAIT_CYCLES == 0`, go to DONE; otherwise load the counter with `WAIT_CYCLES-1` and go to BUSY.
  - IDLE + no req: stay in IDLE.
  - BUSY: decrement the counter each cycle. When the counter is 0, go to DONE.
  - DONE: always go to IDLE on the next edge.
- On the edge entering DONE:
  - If MemWriteM, the word is written with WriteDataM.
  - ReadDataM is loaded with the addressed word's contents as they were before the write (read-before-write).
- With MemWriteM and MemtoRegM both high, the write is performed and ReadDataM returns the old word.
- `MemStallM = (state==IDLE & req) | (state==BUSY)`. It is combinational and low in DONE, which lets the pipeline advance.
- Request inputs must be held stable while MemStallM is high. They are sampled only on the edge entering DONE.
- Memory array is not reset. Contents are undefined until written.

## Timing
- The request first seen in IDLE is cycle 0.
- DONE is reached in cycle `WAIT_CYCLES+1`.
- MemStallM is high for exactly `WAIT_CYCLES+1` cycles per access.
- ReadDataM is valid in the DONE cycle and held until the next access completes.
- A new request may begin in the cycle after DONE. Back-to-back accesses cost `WAIT_CYCLES+2` cycles each.
- Reset values:
  - state IDLE, counter 0, ReadDataM 0, MisalignM 0.
  - MemStallM follows req while reset is asserted (state is IDLE).
- Reset asserted mid-access (IDLE with req, or BUSY): return immediately to IDLE. No write is performed and ReadDataM is cleared to 0.
- Req deasserted during BUSY (illegal) still completes the access using the values sampled at the DONE edge. A write occurs only if MemWriteM is high at that edge.

## Configuration
- Macro `DMEM_MISALIGN_EXC_EN`.
- Defined:
  - An access with `ALUOutM[1:0] != 0` still runs the full wait sequence.
  - On the DONE edge the write is suppressed and ReadDataM is loaded with 0.
  - MisalignM is high for exactly the DONE cycle.
- Not defined:
  - `ALUOutM[1:0]` is ignored; accesses go to the containing word.
  - MisalignM is tied to 0.

## Test plan
- **Store then load, WAIT_CYCLES=2:**
  - Store 0xDEADBEEF to 0x40 -> MemStallM high 3 cycles.
  - Load 0x40 -> ReadDataM=0xDEADBEEF in its DONE cycle, with MemStallM low in that cycle.
- **WAIT_CYCLES=0:** each access stalls exactly 1 cycle. Two consecutive loads complete 2 cycles apart.
- **Wrap, ADDR_BITS=4:** store 0x12345678 to 0x00, then load 0x40 -> ReadDataM=0x12345678.
- **Simultaneous enables:** word 0x10 holds 0xAAAA0000. MemWriteM and MemtoRegM both high with data 0x5555FFFF -> ReadDataM=0xAAAA0000. A subsequent load of 0x10 returns 0x5555FFFF.
- **Reset mid-access:** assert reset during BUSY of a store of 0x11111111 to 0x20 -> state IDLE, ReadDataM=0. A later load of 0x20 returns its prior value (0xCAFEF00D), not 0x11111111.
- **Misaligned store to 0x22 with data 0x0BADF00D:**
  - With macro: MisalignM=1 for one cycle, ReadDataM=0, and word 0x20 is unchanged.
  - Without macro: MisalignM=0 and word 0x20 becomes 0x0BADF00D.
